// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared bf16 field constants and result-writer FSM state type
package bf16_pkg;

    localparam int          BF16_EXP_MSB  = 14;
    localparam int          BF16_EXP_LSB  = 7;
    localparam logic [7:0]  BF16_EXP_ALL1 = 8'hFF;
    localparam logic [15:0] BF16_ZERO     = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } wr_state_t;

endpackage

// File: rtl/bf16_result_ram.sv
// rtl/bf16_result_ram.sv - DEPTH x W single-write, registered-read result array (contents not reset)
module bf16_result_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Read samples the pre-write contents, giving read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bf16_fma_result_writer.sv
// rtl/bf16_fma_result_writer.sv - captures a burst of bf16 FMA results into a readable buffer; optional BF16_SPECIAL_DETECT_EN adds Inf/NaN tracking
module bf16_fma_result_writer
    import bf16_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_result,
    input  logic          in_ov,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count,
    output logic [AW:0]   ov_count,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          rd_ov
`ifdef BF16_SPECIAL_DETECT_EN
    ,
    output logic [AW:0]   special_count,
    output logic          nan_seen
`endif
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    wr_state_t     state, state_nxt;
    logic [AW:0]   eff_len;
    logic [AW:0]   len_clamped;
    logic [AW-1:0] wptr;
    logic          hs;
    logic          start_acc;
    logic          rd_hit;
    logic [16:0]   ram_q;

    assign len_clamped = (len > DEPTH_W) ? DEPTH_W : len;
    assign start_acc   = start && (state != ST_CAPTURE);
    assign hs          = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (len_clamped == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs && ((wr_count + ONE_W) == eff_len)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = (len_clamped == '0) ? ST_DONE : ST_CAPTURE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rd_hit is the registered twin of the RAM read, so entries at or beyond
    // the write count (including a same-cycle write target) read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            eff_len  <= '0;
            wptr     <= '0;
            wr_count <= '0;
            ov_count <= '0;
            rd_hit   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_hit <= ({1'b0, rd_addr} < wr_count);
            if (start_acc) begin
                eff_len  <= len_clamped;
                wptr     <= '0;
                wr_count <= '0;
                ov_count <= '0;
            end else if (hs) begin
                wptr     <= wptr + 1'b1;
                wr_count <= wr_count + ONE_W;
                if (in_ov) ov_count <= ov_count + ONE_W;
            end
        end
    end

`ifdef BF16_SPECIAL_DETECT_EN
    logic exp_all1;
    logic mant_nz;

    assign exp_all1 = (in_result[BF16_EXP_MSB:BF16_EXP_LSB] == BF16_EXP_ALL1);
    assign mant_nz  = (in_result[BF16_EXP_LSB-1:0] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_count <= '0;
            nan_seen      <= 1'b0;
        end else if (start_acc) begin
            special_count <= '0;
            nan_seen      <= 1'b0;
        end else if (hs && exp_all1) begin
            special_count <= special_count + ONE_W;
            if (mant_nz) nan_seen <= 1'b1;
        end
    end
`endif

    bf16_result_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (17)
    ) u_ram (
        .clk   (clk),
        .we    (hs),
        .waddr (wptr),
        .wdata ({in_ov, in_result}),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign rd_data = rd_hit ? ram_q[15:0] : BF16_ZERO;
    assign rd_ov   = rd_hit & ram_q[16];

endmodule

// File: tb/tb_bf16_fma_result_writer.sv
// tb/tb_bf16_fma_result_writer.sv - directed scoreboard bench for bf16_fma_result_writer
module tb_bf16_fma_result_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_result;
    logic          in_ov;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [AW:0]   ov_count;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          rd_ov;
`ifdef BF16_SPECIAL_DETECT_EN
    logic [AW:0]   special_count;
    logic          nan_seen;
`endif

    int checks = 0;
    int errors = 0;
    logic [16:0] sb [$];
    logic [16:0] exp_e;

    always #5 clk = ~clk;

    bf16_fma_result_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_ov     (in_ov),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .ov_count  (ov_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ov     (rd_ov)
`ifdef BF16_SPECIAL_DETECT_EN
        ,
        .special_count (special_count),
        .nan_seen      (nan_seen)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int n);
        start = 1'b1;
        len   = (AW+1)'(n);
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] r, input logic ov);
        in_valid  = 1'b1;
        in_result = r;
        in_ov     = ov;
        sb.push_back({ov, r});
        step();
        in_valid  = 1'b0;
    endtask

    // Pops expected entries in address order from 0 and compares the registered read.
    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            step();
            exp_e = sb.pop_front();
            check("rd_data", 32'(rd_data), 32'(exp_e[15:0]));
            check("rd_ov", 32'(rd_ov), 32'(exp_e[16]));
        end
    endtask

    task automatic read_zero(input int a);
        rd_addr = AW'(a);
        step();
        check("rd_data_hidden", 32'(rd_data), 32'h0);
        check("rd_ov_hidden", 32'(rd_ov), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_result = '0; in_ov = 1'b0; rd_addr = '0;
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_wr_count", 32'(wr_count), 32'h0);
        check("rst_ov_count", 32'(ov_count), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_ov", 32'(rd_ov), 32'h0);
        rst_n = 1'b1;
        step();

        // Basic burst of three back-to-back beats
        arm(3);
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_result = 16'h3F80; in_ov = 1'b0; sb.push_back(17'h03F80); step();
        in_result = 16'h4000; in_ov = 1'b0; sb.push_back(17'h04000); step();
        check("basic_done_early", 32'(done), 32'h0);
        in_result = 16'h7F80; in_ov = 1'b1; sb.push_back(17'h17F80); step();
        in_valid = 1'b0;
        check("basic_done", 32'(done), 32'h1);
        check("basic_ready_off", 32'(in_ready), 32'h0);
        check("basic_wr_count", 32'(wr_count), 32'd3);
        check("basic_ov_count", 32'(ov_count), 32'd1);
        readback(3);
        read_zero(3);

        // Stalls plus a start pulse that must be ignored mid-burst
        arm(2);
        beat(16'hC0A0, 1'b1);
        step();
        check("stall_ready", 32'(in_ready), 32'h1);
        check("stall_wr_count", 32'(wr_count), 32'd1);
        start = 1'b1; len = (AW+1)'(5);
        step();
        start = 1'b0;
        check("ign_start_busy", 32'(busy), 32'h1);
        check("ign_start_wr_count", 32'(wr_count), 32'd1);
        check("ign_start_ready", 32'(in_ready), 32'h1);
        beat(16'h0001, 1'b0);
        check("stall_done", 32'(done), 32'h1);
        check("stall_wr_count2", 32'(wr_count), 32'd2);
        check("stall_ov_count", 32'(ov_count), 32'd1);
        readback(2);
        read_zero(2);

        // Length above DEPTH clamps to a full buffer
        arm(20);
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("clamp_ready", 32'(in_ready), 32'h1);
            in_result = 16'h4000 + 16'(i);
            in_ov     = i[0];
            sb.push_back({i[0], 16'h4000 + 16'(i)});
            step();
        end
        check("clamp_done", 32'(done), 32'h1);
        check("clamp_ready_off", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0;
        check("clamp_wr_count", 32'(wr_count), 32'd16);
        check("clamp_ov_count", 32'(ov_count), 32'd8);
        readback(DEPTH);

        // Zero length goes straight to DONE
        arm(0);
        check("zero_done", 32'(done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_wr_count", 32'(wr_count), 32'd0);
        read_zero(0);

        // Reset mid-burst then re-arm
        arm(4);
        beat(16'hAAAA, 1'b1);
        beat(16'hBBBB, 1'b1);
        sb.delete();
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_ready", 32'(in_ready), 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        check("mrst_wr_count", 32'(wr_count), 32'h0);
        check("mrst_ov_count", 32'(ov_count), 32'h0);
        check("mrst_rd_data", 32'(rd_data), 32'h0);
        check("mrst_rd_ov", 32'(rd_ov), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        arm(1);
        beat(16'h1234, 1'b1);
        check("rearm_done", 32'(done), 32'h1);
        check("rearm_wr_count", 32'(wr_count), 32'd1);
        readback(1);
        read_zero(1);

`ifdef BF16_SPECIAL_DETECT_EN
        arm(3);
        beat(16'h7F80, 1'b0);
        beat(16'h7FC1, 1'b0);
        beat(16'h3F80, 1'b0);
        check("special_count", 32'(special_count), 32'd2);
        check("nan_seen", 32'(nan_seen), 32'h1);
        arm(1);
        check("special_clr", 32'(special_count), 32'd0);
        check("nan_clr", 32'(nan_seen), 32'h0);
        beat(16'h3F80, 1'b0);
        sb.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf16_fma_result_writer.md
Name: bf16_fma_result_writer

Overview:
- Sink-side counterpart to the bfloat16 FMA datapath (A*B+C): captures a burst of FMA results (16-bit bf16 result plus overflow flag) over a valid/ready handshake into an internal result buffer.
- The buffer is read back later through a registered read port.
- Tracks the write count, the overflow count and burst completion, so a test harness or controller can collect results instead of preloading operands from a memory file.

Parameters:
DEPTH, 16, number of result entries in the buffer (power of two, >=2)
AW, 4, address width, equals log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that arms a new capture burst
len  input  AW+1  burst length, sampled on an accepted start
in_valid  input  1  result beat valid
in_ready  output  1  block can accept a beat this cycle
in_result  input  16  bf16 result from the FMA
in_ov  input  1  overflow flag accompanying in_result
busy  output  1  high while in CAPTURE
done  output  1  high in DONE, burst complete
wr_count  output  AW+1  entries written in the current burst
ov_count  output  AW+1  accepted beats with in_ov=1 in the current burst
rd_addr  input  AW  read address
rd_data  output  16  registered read data
rd_ov  output  1  registered overflow bit of the entry

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready, busy, done = 0.
  - wr_count, ov_count, rd_data, rd_ov = 0.
  - Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE or DONE with start=1 (accepted start):
  - latch eff_len = min(len, DEPTH); clear the write pointer, wr_count, ov_count; clear done.
  - If eff_len=0: next state DONE. Otherwise: next state CAPTURE.
- start while in CAPTURE is ignored. It does not restart or abort the burst.
- CAPTURE:
  - in_ready=1 and busy=1, combinationally from state.
  - Handshake = in_valid & in_ready.
  - On a handshake: mem[wptr] <= in_result; ovmem[wptr] <= in_ov; wptr and wr_count increment; ov_count increments if in_ov=1.
  - When the handshake takes wr_count to eff_len, the next state is DONE in the same edge.
  - in_valid=0 stalls with no state change. There is no timeout.
- DONE: done=1, in_ready=0. The state holds until the next accepted start.
- Throughput: one beat per clock. A burst of N beats with in_valid held high has done=1 on the cycle after the Nth handshake.
- Counters never wrap: wr_count <= eff_len <= DEPTH, so AW+1 bits suffice.
- Read port:
  - rd_data/rd_ov are registered from rd_addr, 1-cycle latency, in every state. A read during CAPTURE returns the latest written data.
  - If rd_addr >= wr_count, rd_data=16'h0000 and rd_ov=0. Stale entries from an earlier burst are never exposed.
  - A same-cycle write and read of the same address returns the old value (read-before-write). Because of the wr_count gating, that means 0.
- Reset mid-burst aborts the burst immediately: IDLE, counters cleared.

Optional Feature:
- Macro: BF16_SPECIAL_DETECT_EN.
- When defined:
  - Adds output special_count (AW+1). It counts accepted beats whose in_result exponent field [14:7] == 8'hFF (Inf or NaN).
  - It is cleared by reset and by an accepted start.
  - Adds output nan_seen. It is a sticky flag set when exponent=8'hFF and mantissa [6:0] != 0, cleared by reset and by an accepted start.
- When undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package bf16_pkg:
  - constants BF16_EXP_MSB=14, BF16_EXP_LSB=7, BF16_EXP_ALL1=8'hFF, BF16_ZERO=16'h0000;
  - FSM state typedef (IDLE/CAPTURE/DONE).
- One natural sub-module: bf16_result_ram. It is a DEPTH x 17 single-write, registered-read array holding {ov, result}. The FSM, counters and read-gating stay in the top.

Test Plan:
- Basic burst:
  - Stimulus: reset, start with len=3, beats 16'h3F80/ov0, 16'h4000/ov0, 16'h7F80/ov1 back-to-back.
  - Required: done=1 on the cycle after the 3rd beat; wr_count=3, ov_count=1; reads of addr 0..2 return those values with 1-cycle latency; addr 3 returns 0.
- Stall and ignored start:
  - Stimulus: len=2, in_valid toggles 1,0,0,1; start pulsed mid-burst.
  - Required: in_ready stays 1; exactly 2 entries written; start ignored; done asserted after the 2nd handshake.
- Length clamp and zero length:
  - Stimulus: len=20 with DEPTH=16.
  - Required: exactly 16 beats accepted, then in_ready=0 and done=1.
  - Stimulus: len=0.
  - Required: DONE on the next cycle with wr_count=0.
- Reset mid-burst and re-arm:
  - Stimulus: rst_n low after 2 of 4 beats.
  - Required: all outputs 0; a new start with len=1 writes addr 0; a read of addr 1 returns 0, old data hidden.
- Feature on (BF16_SPECIAL_DETECT_EN):
  - Stimulus: beats 16'h7F80, 16'h7FC1, 16'h3F80.
  - Required: special_count=2 and nan_seen=1; both clear on the next accepted start.
